uart_frame_ctrl: RTL and testbench

// - Sequences the UART link: consumes the RX byte stream, frames packets SYNC,LEN,PAYLOAD,CHK, and

---
 rtl/uart_pkg.sv | 24 ++
 rtl/frame_buf.sv | 25 ++
 rtl/uart_frame_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART link definitions: frame controller states, protocol byte defaults, bit timing.
// Pure declarations; no logic and therefore no latency or backpressure of its own.
package uart_pkg;

    localparam int CLKS_PER_BIT = 10416;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE_DEF  = 8'h5A;
    localparam logic [7:0] NAK_BYTE_DEF  = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_LEN,
        ST_RX_DATA,
        ST_RX_CHK,
        ST_TX_ACK,
        ST_TX_LEN,
        ST_TX_DATA,
        ST_TX_CHK,
        ST_TX_NAK,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/frame_buf.sv
// Payload store: DEPTH x 8 registers, synchronous write, combinational read, no reset on storage.
// Read data follows raddr in the same cycle; a write is visible on the cycle after we.
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames SYNC,LEN,PAYLOAD,CHK from the UART receiver, checks the XOR sum, echoes ACK+frame or NAK.
// Last RX byte to tx_start is 2 clk; one byte in flight to the transmitter, RX bytes during TX are dropped and counted.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 208320,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [7:0] ACK_BYTE     = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE     = NAK_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] ovr_cnt
);

    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    state_t        state, state_nxt;
    state_t        last, last_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [LW-1:0] idx, idx_nxt;
    logic [7:0]    chk, chk_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [7:0]    ovr_nxt;
    logic          tx_start_nxt;
    logic [7:0]    tx_byte_nxt;
    logic          frame_ok_nxt;
    logic          frame_err_nxt;
    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          in_rx;
    logic          tmo_hit;

    frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_frame_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx[AW-1:0]),
        .wdata (rx_byte),
        .raddr (idx[AW-1:0]),
        .rdata (buf_rdata)
    );

    assign in_rx   = (state inside {ST_RX_LEN, ST_RX_DATA, ST_RX_CHK});
    assign tmo_hit = (tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last      <= ST_IDLE;
            len       <= '0;
            idx       <= '0;
            chk       <= '0;
            tmo       <= '0;
            ovr_cnt   <= '0;
            tx_start  <= 1'b0;
            tx_byte   <= '0;
            busy      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            len       <= len_nxt;
            idx       <= idx_nxt;
            chk       <= chk_nxt;
            tmo       <= tmo_nxt;
            ovr_cnt   <= ovr_nxt;
            tx_start  <= tx_start_nxt;
            tx_byte   <= tx_byte_nxt;
            busy      <= (state_nxt != ST_IDLE);
            frame_ok  <= frame_ok_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        len_nxt       = len;
        idx_nxt       = idx;
        chk_nxt       = chk;
        tmo_nxt       = tmo;
        ovr_nxt       = ovr_cnt;
        tx_start_nxt  = 1'b0;
        tx_byte_nxt   = tx_byte;
        frame_ok_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        buf_we        = 1'b0;

        // The counter only runs while a frame is being received; an arriving byte restarts it.
        if (in_rx) begin
            tmo_nxt = rx_dv ? '0 : tmo + TW'(1);
        end

        if (rx_dv && !in_rx && state != ST_IDLE && ovr_cnt != 8'hFF) begin
            ovr_nxt = ovr_cnt + 8'd1;
        end

        case (state)
            ST_IDLE: begin
                if (rx_dv && rx_byte == SYNC_BYTE) begin
                    state_nxt = ST_RX_LEN;
                    tmo_nxt   = '0;
                end
            end
            ST_RX_LEN: begin
                if (rx_dv) begin
                    if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAX_LEN_W) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_TX_NAK;
                    end else begin
                        len_nxt   = LW'(rx_byte);
                        chk_nxt   = rx_byte;
                        idx_nxt   = '0;
                        state_nxt = ST_RX_DATA;
                    end
                end else if (tmo_hit) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_TX_NAK;
                end
            end
            ST_RX_DATA: begin
                if (rx_dv) begin
                    buf_we  = 1'b1;
                    chk_nxt = chk ^ rx_byte;
                    idx_nxt = idx + LW'(1);
                    if (idx + LW'(1) == len) begin
                        state_nxt = ST_RX_CHK;
                    end
                end else if (tmo_hit) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_TX_NAK;
                end
            end
            ST_RX_CHK: begin
                if (rx_dv) begin
                    if (rx_byte == chk) begin
                        state_nxt = ST_TX_ACK;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_TX_NAK;
                    end
                end else if (tmo_hit) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_TX_NAK;
                end
            end
            ST_TX_ACK, ST_TX_LEN, ST_TX_DATA, ST_TX_CHK, ST_TX_NAK: begin
                tx_start_nxt = 1'b1;
                last_nxt     = state;
                state_nxt    = ST_WAIT_DONE;
                case (state)
                    ST_TX_ACK:  tx_byte_nxt = ACK_BYTE;
                    ST_TX_LEN:  tx_byte_nxt = 8'(len);
                    ST_TX_DATA: tx_byte_nxt = buf_rdata;
                    ST_TX_CHK:  tx_byte_nxt = chk;
                    default:    tx_byte_nxt = NAK_BYTE;
                endcase
            end
            ST_WAIT_DONE: begin
                // 'last' records which byte is on the wire, so one wait state serves the whole echo.
                if (tx_done) begin
                    case (last)
                        ST_TX_ACK: state_nxt = ST_TX_LEN;
                        ST_TX_LEN: begin
                            idx_nxt   = '0;
                            state_nxt = ST_TX_DATA;
                        end
                        ST_TX_DATA: begin
                            if (idx == len - LW'(1)) begin
                                state_nxt = ST_TX_CHK;
                            end else begin
                                idx_nxt   = idx + LW'(1);
                                state_nxt = ST_TX_DATA;
                            end
                        end
                        ST_TX_CHK: begin
                            frame_ok_nxt = 1'b1;
                            state_nxt    = ST_IDLE;
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed frames against uart_frame_ctrl; expected TX bytes queued at stimulus time, checked by a negedge monitor.
// Transmitter modelled as tx_done a programmable number of clocks after tx_start.
module tb_uart_frame_ctrl;

    localparam int T = 64;

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] ovr_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    int ok_exp   = 0;
    int err_exp  = 0;
    int done_dly = 10;
    logic outstanding = 1'b0;
    logic [7:0] exp_tx[$];

    uart_frame_ctrl #(
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_done   (tx_done),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .ovr_cnt   (ovr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                repeat (done_dly) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (frame_ok)  ok_cnt++;
            if (frame_err) err_cnt++;
            if (tx_start) begin
                check("tx_start_before_done", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tx_start: got byte %02h expected none", tx_byte);
                end else begin
                    check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
                end
            end
            if (tx_done) outstanding = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1 rx_dv = 1'b0;
        for (int i = 1; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 5);
    endtask

    task automatic expect_seq(input logic [7:0] q[$]);
        foreach (q[i]) exp_tx.push_back(q[i]);
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_tx.size() == 0) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_idle: got busy=%0b pending=%0d expected idle", name, busy, exp_tx.size());
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_frame_ok_cnt"}, 32'(ok_cnt), 32'(ok_exp));
        check({name, "_frame_err_cnt"}, 32'(err_cnt), 32'(err_exp));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tx_start"},  32'(tx_start),  32'd0);
        check({name, "_tx_byte"},   32'(tx_byte),   32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
        check({name, "_frame_ok"},  32'(frame_ok),  32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_ovr_cnt"},   32'(ovr_cnt),   32'd0);
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] e[$];
        logic [7:0] c;
        int k;

        rst_n   = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good frame: chk = 03^11^22^33 = 03
        e = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        expect_seq(e);
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq(s);
        ok_exp++;
        wait_idle("good3");

        // Bad checksum: 02^10^20 = 32, FF sent
        exp_tx.push_back(8'hEE);
        send_byte(8'hA5, 5); send_byte(8'h02, 5); send_byte(8'h10, 5); send_byte(8'h20, 5);
        send_byte(8'hFF, 1);
        check("badchk_frame_err_next_clk", 32'(frame_err), 32'd1);
        err_exp++;
        wait_idle("badchk");
        check("badchk_busy", 32'(busy), 32'd0);

        // Zero and oversize lengths
        exp_tx.push_back(8'hEE);
        send_byte(8'hA5, 5); send_byte(8'h00, 1);
        check("len0_frame_err", 32'(frame_err), 32'd1);
        err_exp++;
        wait_idle("len0");
        exp_tx.push_back(8'hEE);
        send_byte(8'hA5, 5); send_byte(8'h11, 1);
        check("len17_frame_err", 32'(frame_err), 32'd1);
        err_exp++;
        wait_idle("len17");

        // Maximum length 16
        s = '{8'hA5, 8'h10};
        e = '{8'h5A, 8'h10};
        c = 8'h10;
        for (int i = 0; i < 16; i++) begin
            s.push_back(8'(i * 17 + 3));
            e.push_back(8'(i * 17 + 3));
            c = c ^ 8'(i * 17 + 3);
        end
        s.push_back(c);
        e.push_back(c);
        expect_seq(e);
        send_seq(s);
        ok_exp++;
        wait_idle("len16");

        // Timeout: frame_err rises T clock edges after the edge that took AA
        exp_tx.push_back(8'hEE);
        send_byte(8'hA5, 5); send_byte(8'h02, 5); send_byte(8'hAA, 1);
        k = 0;
        for (int i = 1; i <= T + 10; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                k = i;
                break;
            end
        end
        check("timeout_latency", 32'(k), 32'(T));
        err_exp++;
        wait_idle("timeout");

        // Bytes at T-1 and at T clocks (rx_dv wins the tie): chk = 02^AA^55 = FD
        e = '{8'h5A, 8'h02, 8'hAA, 8'h55, 8'hFD};
        expect_seq(e);
        send_byte(8'hA5, 5); send_byte(8'h02, 5); send_byte(8'hAA, T - 1);
        send_byte(8'h55, T); send_byte(8'hFD, 5);
        ok_exp++;
        wait_idle("no_timeout");

        // Overrun during echo: chk = 02^C3^3C = FD
        e = '{8'h5A, 8'h02, 8'hC3, 8'h3C, 8'hFD};
        expect_seq(e);
        send_byte(8'hA5, 5); send_byte(8'h02, 5); send_byte(8'hC3, 5); send_byte(8'h3C, 5);
        send_byte(8'hFD, 1);
        send_byte(8'hA5, 5); send_byte(8'hA5, 5); send_byte(8'h00, 5);
        ok_exp++;
        wait_idle("overrun");
        check("ovr_cnt_3", 32'(ovr_cnt), 32'd3);

        // Slow transmitter, 300 drops saturate the counter
        done_dly = 1000;
        exp_tx.push_back(8'hEE);
        send_byte(8'hA5, 5); send_byte(8'h00, 1);
        err_exp++;
        for (int i = 0; i < 100; i++) send_byte(8'hA5, 2);
        check("ovr_cnt_103", 32'(ovr_cnt), 32'd103);
        for (int i = 0; i < 200; i++) send_byte(8'hA5, 2);
        check("ovr_cnt_sat", 32'(ovr_cnt), 32'hFF);
        check("slow_busy", 32'(busy), 32'd1);
        wait_idle("slow_tx");
        done_dly = 10;

        // Reset in RX_DATA
        send_byte(8'hA5, 5); send_byte(8'h04, 5); send_byte(8'h01, 2);
        check("pre_rst_rx_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst_rx");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset in the data phase of an echo
        e = '{8'h5A, 8'h03, 8'h11};
        expect_seq(e);
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq(s);
        repeat (32) @(posedge clk);
        #1;
        check("pre_rst_tx_byte", 32'(tx_byte), 32'h11);
        check("pre_rst_tx_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        exp_tx.delete();
        #1 check_reset_outputs("rst_tx");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Recovery frame: chk = 01^7E = 7F
        e = '{8'h5A, 8'h01, 8'h7E, 8'h7F};
        expect_seq(e);
        s = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(s);
        ok_exp++;
        wait_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
